// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul scheduler: default sizes, FSM state
// encoding and the column-tile count helper.
package matmul_pkg;

  localparam int P_DEF     = 8;
  localparam int AW_DEF    = 10;
  localparam int DIM_W_DEF = 8;

  // state   | meaning
  // IDLE    | waiting for start, cfg not yet latched
  // RUN     | one operand read per cycle, k advancing
  // DRAIN   | no read; last MAC of the row completes
  // WB      | result row presented, waiting for wb_ready
  // DONE    | one-cycle completion pulse
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Number of P-wide column tiles needed to cover n output columns.
  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// Loop counters and operand address accumulators for the matmul scheduler.
// Addresses are built from running bases (no multipliers): the A row base
// steps by K per row, the B pointer steps by NT per k and restarts at the
// tile index t for every row.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int P     = P_DEF,
  parameter int AW    = AW_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             init,
  input  logic             k_step,
  input  logic             row_adv,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_k,
  input  logic [DIM_W-1:0] cfg_nt,
  output logic [AW-1:0]    a_addr,
  output logic [AW-1:0]    b_addr,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic             k_first,
  output logic             k_last,
  output logic             r_last,
  output logic             t_last
);

  logic [DIM_W-1:0] k_cnt;
  logic [DIM_W-1:0] r_cnt;
  logic [DIM_W-1:0] t_cnt;
  logic [DIM_W-1:0] col_base;
  logic [AW-1:0]    a_base;
  logic [AW-1:0]    b_ptr;
  logic [AW-1:0]    b_tile;

  assign k_first = (k_cnt == '0);
  assign k_last  = (k_cnt == cfg_k - DIM_W'(1));
  assign r_last  = (r_cnt == cfg_m - DIM_W'(1));
  assign t_last  = (t_cnt == cfg_nt - DIM_W'(1));

  assign a_addr = a_base + AW'(k_cnt);
  assign b_addr = b_ptr;
  assign row    = r_cnt;
  assign col    = col_base;

  // Counter/accumulator update: k inner loop, r middle, t outer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      k_cnt    <= '0;
      r_cnt    <= '0;
      t_cnt    <= '0;
      col_base <= '0;
      a_base   <= '0;
      b_ptr    <= '0;
      b_tile   <= '0;
    end else if (init) begin
      k_cnt    <= '0;
      r_cnt    <= '0;
      t_cnt    <= '0;
      col_base <= '0;
      a_base   <= '0;
      b_ptr    <= '0;
      b_tile   <= '0;
    end else begin
      if (k_step) begin
        if (k_last) begin
          k_cnt <= '0;
          b_ptr <= b_tile;
        end else begin
          k_cnt <= k_cnt + DIM_W'(1);
          b_ptr <= b_ptr + AW'(cfg_nt);
        end
      end
      // k_step and row_adv are never high together (RUN vs WB).
      if (row_adv) begin
        if (r_last) begin
          r_cnt    <= '0;
          a_base   <= '0;
          t_cnt    <= t_cnt + DIM_W'(1);
          col_base <= col_base + DIM_W'(P);
          b_tile   <= b_tile + AW'(1);
          b_ptr    <= b_tile + AW'(1);
        end else begin
          r_cnt  <= r_cnt + DIM_W'(1);
          a_base <= a_base + AW'(cfg_k);
        end
      end
    end
  end

endmodule

// File: rtl/matmul_sched.sv
// Matmul scheduler top: latches the job configuration, runs the
// IDLE/RUN/DRAIN/WB/DONE sequence and drives read, MAC and write-back
// strobes. Optional busy-cycle counter enabled by MATMUL_SCHED_PERF_EN;
// without it perf_cycles is constant zero.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | rd_en high, one k per cycle
// DRAIN   | rd_en low, final mac_en of the row
// WB      | wb_valid high until wb_ready
// DONE    | done pulse, then back to IDLE
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int P     = P_DEF,
  parameter int AW    = AW_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_k,
  input  logic [DIM_W-1:0] cfg_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_en,
  output logic [AW-1:0]    a_addr,
  output logic [AW-1:0]    b_addr,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [DIM_W-1:0] wb_row,
  output logic [DIM_W-1:0] wb_col,
  output logic [31:0]      perf_cycles
);

  state_t           state_q;
  state_t           state_d;
  logic [DIM_W-1:0] m_q;
  logic [DIM_W-1:0] k_q;
  logic [DIM_W-1:0] nt_q;
  logic             err_q;
  logic             mac_en_q;
  logic             mac_clr_q;
  logic             accept;
  logic             zero_dim;
  logic             k_step;
  logic             row_adv;
  logic             k_first;
  logic             k_last;
  logic             r_last;
  logic             t_last;

  assign zero_dim = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);
  assign accept   = (state_q == ST_IDLE) && start;

  assign err     = err_q;
  assign mac_en  = mac_en_q;
  assign mac_clr = mac_clr_q;

  matmul_addr_gen #(
    .P     (P),
    .AW    (AW),
    .DIM_W (DIM_W)
  ) u_addr_gen (
    .clk     (clk),
    .resetn  (resetn),
    .init    (accept),
    .k_step  (k_step),
    .row_adv (row_adv),
    .cfg_m   (m_q),
    .cfg_k   (k_q),
    .cfg_nt  (nt_q),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .row     (wb_row),
    .col     (wb_col),
    .k_first (k_first),
    .k_last  (k_last),
    .r_last  (r_last),
    .t_last  (t_last)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; outputs depend on state only, so reset
  // drives them low immediately.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    done     = 1'b0;
    rd_en    = 1'b0;
    wb_valid = 1'b0;
    k_step   = 1'b0;
    row_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = zero_dim ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        rd_en  = 1'b1;
        k_step = 1'b1;
        if (k_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          row_adv = 1'b1;
          state_d = (r_last && t_last) ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Job configuration, captured only when a start is accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_q   <= '0;
      k_q   <= '0;
      nt_q  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      m_q   <= cfg_m;
      k_q   <= cfg_k;
      nt_q  <= DIM_W'(ceil_div(32'(cfg_n), P));
      err_q <= zero_dim;
    end
  end

  // MAC strobes trail the read by the one-cycle memory latency; clear rides
  // with the first k of each row so the accumulator loads instead of adds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
    end else begin
      mac_en_q  <= rd_en;
      mac_clr_q <= rd_en && k_first;
    end
  end

`ifdef MATMUL_SCHED_PERF_EN
  logic [31:0] perf_q;

  // Busy-cycle counter; holds after done until the next accepted start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_matmul_sched.sv
`timescale 1ns/1ps
module tb_matmul_sched;
  import matmul_pkg::*;

  localparam int P     = 8;
  localparam int AW    = 10;
  localparam int DIM_W = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [DIM_W-1:0] cfg_m = '0;
  logic [DIM_W-1:0] cfg_k = '0;
  logic [DIM_W-1:0] cfg_n = '0;
  logic             busy, done, err, rd_en, mac_en, mac_clr, wb_valid;
  logic             wb_ready = 1'b1;
  logic [AW-1:0]    a_addr, b_addr;
  logic [DIM_W-1:0] wb_row, wb_col;
  logic [31:0]      perf_cycles;

  always #5 clk = ~clk;

  matmul_sched #(.P(P), .AW(AW), .DIM_W(DIM_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .cfg_m       (cfg_m),
    .cfg_k       (cfg_k),
    .cfg_n       (cfg_n),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rd_en       (rd_en),
    .a_addr      (a_addr),
    .b_addr      (b_addr),
    .mac_en      (mac_en),
    .mac_clr     (mac_clr),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_row      (wb_row),
    .wb_col      (wb_col),
    .perf_cycles (perf_cycles)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic          clr;
  } rd_t;

  typedef struct {
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
  } wb_t;

  rd_t  rd_q[$];
  wb_t  wb_q[$];
  rd_t  mon_rd;
  wb_t  mon_wb;
  int   n_checks = 0;
  int   n_errors = 0;
  logic pend_vld = 1'b0;
  logic pend_clr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected read stream and write-back order: t outer, r middle, k inner.
  task automatic push_job(input int m, input int k, input int n);
    int  nt;
    rd_t e;
    wb_t w;
    nt = (n + P - 1) / P;
    for (int t = 0; t < nt; t++) begin
      for (int r = 0; r < m; r++) begin
        for (int kk = 0; kk < k; kk++) begin
          e.a   = AW'(r * k + kk);
          e.b   = AW'(kk * nt + t);
          e.clr = (kk == 0);
          rd_q.push_back(e);
        end
        w.row = DIM_W'(r);
        w.col = DIM_W'(t * P);
        wb_q.push_back(w);
      end
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!resetn) begin
      pend_vld = 1'b0;
    end else begin
      if (pend_vld) begin
        check("mac_en", {31'd0, mac_en}, 32'd1);
        check("mac_clr", {31'd0, mac_clr}, {31'd0, pend_clr});
      end else begin
        check("mac_idle", {30'd0, mac_en, mac_clr}, 32'd0);
      end
      pend_vld = 1'b0;
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          check("rd_extra", 32'd1, 32'd0);
        end else begin
          mon_rd = rd_q.pop_front();
          check("a_addr", 32'(a_addr), 32'(mon_rd.a));
          check("b_addr", 32'(b_addr), 32'(mon_rd.b));
          pend_vld = 1'b1;
          pend_clr = mon_rd.clr;
        end
      end
      if (wb_valid && wb_ready) begin
        if (wb_q.size() == 0) begin
          check("wb_extra", 32'd1, 32'd0);
        end else begin
          mon_wb = wb_q.pop_front();
          check("wb_row", 32'(wb_row), 32'(mon_wb.row));
          check("wb_col", 32'(wb_col), 32'(mon_wb.col));
        end
      end
    end
  end

  task automatic run_job(input string name, input int m, input int k, input int n,
                         input int stall, input bit intrude, input bit exp_err);
    int nt, lat, cyc, stall_left;
    logic [31:0] exp_perf;
    nt  = (n + P - 1) / P;
    lat = exp_err ? 1 : m * nt * (k + 2) + 1 + stall;
    if (!exp_err) push_job(m, k, n);
`ifdef MATMUL_SCHED_PERF_EN
    exp_perf = 32'(lat);
`else
    exp_perf = 32'd0;
`endif
    stall_left = stall;
    wb_ready   = (stall == 0);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_m = DIM_W'(m);
    cfg_k = DIM_W'(k);
    cfg_n = DIM_W'(n);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (intrude && cyc == 2) begin
        start = 1'b1;
        cfg_m = 8'd3;
        cfg_k = 8'd5;
        cfg_n = 8'd16;
      end
      if (cyc == 1 && !exp_err) check({name, "_busy"}, {31'd0, busy}, 32'd1);
      if (stall_left > 0 && wb_valid) begin
        check({name, "_stall_rd"}, {30'd0, rd_en, mac_en}, 32'd0);
        if (wb_q.size() > 0) begin
          check({name, "_stall_row"}, 32'(wb_row), 32'(wb_q[0].row));
          check({name, "_stall_col"}, 32'(wb_col), 32'(wb_q[0].col));
        end
        stall_left--;
      end else if (stall_left == 0) begin
        wb_ready = 1'b1;
      end
    end while (!done && cyc < lat + 50);
    check({name, "_done_lat"}, 32'(cyc), 32'(lat));
    check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    @(posedge clk); #1;
    check({name, "_done_once"}, {30'd0, done, busy}, 32'd0);
    check({name, "_perf"}, perf_cycles, exp_perf);
    check({name, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    check({name, "_wb_left"}, 32'(wb_q.size()), 32'd0);
    rd_q.delete();
    wb_q.delete();
  endtask

  initial begin
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {26'd0, done, err, rd_en, mac_en, mac_clr, wb_valid}, 32'd0);
    check("rst_addr", {12'd0, a_addr, b_addr}, 32'd0);
    check("rst_wb", {16'd0, wb_row, wb_col}, 32'd0);
    check("rst_perf", perf_cycles, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    run_job("t1", 2, 3, 8, 0, 1'b0, 1'b0);
    run_job("t2", 2, 3, 12, 0, 1'b0, 1'b0);
    run_job("t3", 1, 2, 8, 3, 1'b0, 1'b0);
    run_job("t4k", 2, 0, 8, 0, 1'b0, 1'b1);
    run_job("t4ok", 1, 1, 1, 0, 1'b0, 1'b0);
    run_job("t4m", 0, 3, 8, 0, 1'b0, 1'b1);
    run_job("t4n", 2, 3, 0, 0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of RUN.
    push_job(2, 3, 8);
    wb_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_m = 8'd2;
    cfg_k = 8'd3;
    cfg_n = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("t5_pre_rd", {31'd0, rd_en}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("t5_async", {28'd0, busy, rd_en, wb_valid, done}, 32'd0);
    check("t5_perf", perf_cycles, 32'd0);
    rd_q.delete();
    wb_q.delete();
    @(posedge clk); #1;
    check("t5_hold", {30'd0, busy, mac_en}, 32'd0);
    resetn = 1'b1;
    run_job("t5re", 2, 3, 8, 0, 1'b0, 1'b0);

    run_job("t6", 2, 3, 8, 0, 1'b1, 1'b0);
    run_job("tbig", 3, 4, 20, 0, 1'b0, 1'b0);
    run_job("tk1", 2, 1, 9, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
